register_dump: RTL

REGISTER_DUMP -- requirements
Module: register_dump

---
 rtl/register_dump.sv | 87 ++++++++
 1 files changed

// File: rtl/register_dump.sv
// Walks a register-file read port from FIRST_REG to LAST_REG and streams each
// captured word out over a valid/ready handshake, one word per FETCH/SEND pair.
module register_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  read_register,
    input  logic [31:0] read_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_index,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t     state;
    logic [4:0] idx;

    // read_register only moves when a new FETCH is entered, so it always
    // equals idx during FETCH and otherwise holds the last address issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= FIRST_IDX;
            read_register <= FIRST_IDX;
            dump_valid    <= 1'b0;
            dump_index    <= 5'd0;
            dump_data     <= 32'd0;
            dump_last     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= FIRST_IDX;
                        read_register <= FIRST_IDX;
                        busy          <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    dump_data  <= read_data;
                    dump_index <= idx;
                    dump_last  <= (idx == LAST_IDX);
                    dump_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    // The presented word is frozen until the consumer takes it.
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx           <= idx + 5'd1;
                            read_register <= idx + 5'd1;
                            state         <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
